// File: rtl/hv_spi_pkg.sv
// Shared state encoding, frame geometry and parameter limits for the HV carrier SPI master.
package hv_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  localparam int unsigned SPI_FRAME_BITS  = 16;
  localparam int unsigned SPI_BYTE_BITS   = 8;

  localparam int unsigned HALF_PERIOD_MIN = 6;
  localparam int unsigned HALF_PERIOD_MAX = 255;
  localparam int unsigned CS_SETUP_MIN    = 1;
  localparam int unsigned CS_HOLD_MIN     = 1;
  localparam int unsigned CS_IDLE_MIN     = 4;

  // Width of the SETUP/HOLD/GAP cycle counter.
  localparam int unsigned PHASE_CNT_W     = 16;

  function automatic int unsigned clamp_param(int unsigned value, int unsigned lo,
                                              int unsigned hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/hv_spi_clkgen.sv
// SPI clock phase divider: spi_clk idles low, each phase lasts HALF_PERIOD clk cycles.
// o_rise/o_fall flag the cycle whose closing edge drives spi_clk high/low.
module hv_spi_clkgen
  import hv_spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_en,
  output logic o_spi_clk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] r_div;
  logic       r_spi_clk;
  logic       w_phase_end;

  assign w_phase_end = i_en && (r_div == DIV_LAST);
  assign o_rise      = w_phase_end && !r_spi_clk;
  assign o_fall      = w_phase_end &&  r_spi_clk;
  assign o_spi_clk   = r_spi_clk;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_div     <= '0;
      r_spi_clk <= 1'b0;
    end else if (!i_en) begin
      r_div     <= '0;
      r_spi_clk <= 1'b0;
    end else if (w_phase_end) begin
      r_div     <= '0;
      r_spi_clk <= !r_spi_clk;
    end else begin
      r_div     <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/hv_spi_master.sv
// SPI mode-0 master: each {addr,data} command goes out as one 16-bit CSB frame, MSB first.
// Define HV_SPI_MASTER_BURST_EN to chain back-to-back commands inside one CSB-low window.
module hv_spi_master
  import hv_spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned CS_SETUP    = 4,
  parameter int unsigned CS_HOLD     = 4,
  parameter int unsigned CS_IDLE     = 8
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SPI_BYTE_BITS-1:0]  cmd_addr,
  input  logic [SPI_BYTE_BITS-1:0]  cmd_data,
  output logic                      busy,
  output logic                      done,
  output logic [SPI_FRAME_BITS-1:0] rx_data,
  output logic                      spi_csb,
  output logic                      spi_clk,
  output logic                      spi_dout,
  input  logic                      spi_din
);

  // Out-of-range parameters are pulled to the nearest legal value so timing never breaks the slave.
  localparam int unsigned CNT_MAX  = 2 ** PHASE_CNT_W;
  localparam int unsigned HP_EFF   = clamp_param(HALF_PERIOD, HALF_PERIOD_MIN, HALF_PERIOD_MAX);
  localparam logic [PHASE_CNT_W-1:0] SETUP_LAST =
    PHASE_CNT_W'(clamp_param(CS_SETUP, CS_SETUP_MIN, CNT_MAX) - 1);
  localparam logic [PHASE_CNT_W-1:0] HOLD_LAST =
    PHASE_CNT_W'(clamp_param(CS_HOLD, CS_HOLD_MIN, CNT_MAX) - 1);
  localparam logic [PHASE_CNT_W-1:0] IDLE_LAST =
    PHASE_CNT_W'(clamp_param(CS_IDLE, CS_IDLE_MIN, CNT_MAX) - 1);
  localparam logic [4:0] BIT_LAST = 5'(SPI_FRAME_BITS);

  spi_state_t                r_state;
  logic [PHASE_CNT_W-1:0]    r_cnt;
  logic [4:0]                r_bit_cnt;
  logic [SPI_FRAME_BITS-1:0] r_shift_tx;
  logic [SPI_FRAME_BITS-1:0] r_shift_rx;
  logic [SPI_FRAME_BITS-1:0] r_rx_data;
  logic                      r_csb;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_din_meta;
  logic                      r_din_sync;

  logic                      w_shift_en;
  logic                      w_rise;
  logic                      w_fall;
  logic                      w_spi_clk;
  logic                      w_hold_last;

  assign w_shift_en  = (r_state == SHIFT);
  assign w_hold_last = (r_state == HOLD) && (r_cnt == HOLD_LAST);

`ifdef HV_SPI_MASTER_BURST_EN
  assign cmd_ready = (r_state == IDLE) || w_hold_last;
`else
  assign cmd_ready = (r_state == IDLE);
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign spi_csb  = r_csb;
  assign spi_clk  = w_spi_clk;
  assign spi_dout = r_shift_tx[SPI_FRAME_BITS-1];

  hv_spi_clkgen #(
    .HALF_PERIOD (HP_EFF)
  ) u_clkgen (
    .clk       (clk),
    .rstb      (rstb),
    .i_en      (w_shift_en),
    .o_spi_clk (w_spi_clk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  // spi_din is asynchronous to clk; two flops before anything looks at it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_din_meta <= 1'b0;
      r_din_sync <= 1'b0;
    end else begin
      r_din_meta <= spi_din;
      r_din_sync <= r_din_meta;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift_tx <= '0;
      r_shift_rx <= '0;
      r_rx_data  <= '0;
      r_csb      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_state    <= SETUP;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_shift_tx <= {cmd_addr, cmd_data};
            r_csb      <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (w_rise) begin
            r_shift_rx <= {r_shift_rx[SPI_FRAME_BITS-2:0], r_din_sync};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
          end
          // Zero fill leaves spi_dout low once the last bit has gone out.
          if (w_fall) begin
            r_shift_tx <= {r_shift_tx[SPI_FRAME_BITS-2:0], 1'b0};
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= HOLD;
              r_cnt   <= '0;
            end
          end
        end
        HOLD: begin
          if (w_hold_last) begin
            r_done    <= 1'b1;
            r_rx_data <= r_shift_rx;
`ifdef HV_SPI_MASTER_BURST_EN
            if (cmd_valid) begin
              r_state    <= SHIFT;
              r_cnt      <= '0;
              r_bit_cnt  <= '0;
              r_shift_tx <= {cmd_addr, cmd_data};
            end else begin
              r_state <= GAP;
              r_cnt   <= '0;
              r_csb   <= 1'b1;
            end
`else
            r_state <= GAP;
            r_cnt   <= '0;
            r_csb   <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == IDLE_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_csb   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
